// File: rtl/pc_fetch.sv
// Program-counter register and instruction-fetch sequencer for the CPU front end.
//
// Keeps the fetch PC, issues one instruction-memory request at a time and hands
// each returned word to decode together with its address and address + 4.
// Branch, jump, jr and exception redirects are applied with a fixed priority.
// A fetch already in flight when a redirect arrives is marked for discard.
//
// Ports:
//   clk_i              clock, all state updates on the rising edge
//   reset_i            synchronous, active-high reset
//   stall_i            decode cannot accept; held instruction stays valid
//   branch_taken_i     branch redirect request, target branch_target_i
//   jump_i             j/jal redirect request, target jump_target_i
//   jr_i               jr/jalr redirect request, target jr_target_i
//   exc_i              exception redirect to EXC_VECTOR
//   imem_req_o         fetch request valid
//   imem_addr_o        fetch address, word aligned
//   imem_gnt_i         memory accepted the request this cycle
//   imem_rvalid_i      read data valid, one cycle per accepted request
//   imem_rdata_i       instruction word
//   instr_valid_o      instr_o / pc_out_o / pc4_out_o valid for decode
//   instr_o            fetched instruction
//   pc_out_o           address of instr_o
//   pc4_out_o          pc_out_o + 4
module pc_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
  input  logic        exc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_out_o,
  output logic [31:0] pc4_out_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StOut} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        drop_q, drop_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] pc4_q, pc4_d;

  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;

  assign redirect = exc_i | jr_i | jump_i | branch_taken_i;

  always_comb begin
    target_raw = branch_target_i;
    if (exc_i) begin
      target_raw = EXC_VECTOR;
    end else if (jr_i) begin
      target_raw = jr_target_i;
    end else if (jump_i) begin
      target_raw = jump_target_i;
    end
  end

  assign target = {target_raw[31:2], 2'b00};

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    drop_d        = drop_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    pc4_d         = pc4_q;

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
        if (redirect) begin
          fetch_pc_d = target;
        end
      end

      StReq: begin
        if (imem_gnt_i) begin
          state_d = StWait;
          // The old address is already accepted; its data must be thrown away.
          if (redirect) begin
            drop_d     = 1'b1;
            fetch_pc_d = target;
          end
        end else if (redirect) begin
          // Address is only sampled on gnt, so it can simply be replaced.
          fetch_pc_d = target;
        end
      end

      StWait: begin
        if (imem_rvalid_i) begin
          if (drop_q || redirect) begin
            drop_d  = 1'b0;
            state_d = StReq;
            if (redirect) begin
              fetch_pc_d = target;
            end
          end else begin
            instr_d       = imem_rdata_i;
            pc_out_d      = fetch_pc_q;
            pc4_d         = fetch_pc_q + 32'd4;
            fetch_pc_d    = fetch_pc_q + 32'd4;
            instr_valid_d = 1'b1;
            state_d       = StOut;
          end
        end else if (redirect) begin
          drop_d     = 1'b1;
          fetch_pc_d = target;
        end
      end

      StOut: begin
        // A redirect flushes the held instruction even under stall.
        if (redirect || !stall_i) begin
          instr_valid_d = 1'b0;
          state_d       = StReq;
          if (redirect) begin
            fetch_pc_d = target;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Request flag is registered from the next state so it lines up with state_q.
  assign imem_req_d = (state_d == StReq);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      fetch_pc_q    <= RESET_PC;
      drop_q        <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= 32'h0;
      pc_out_q      <= RESET_PC;
      pc4_q         <= RESET_PC + 32'd4;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      drop_q        <= drop_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      pc4_q         <= pc4_d;
    end
  end

  assign imem_req_o    = imem_req_q;
  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = instr_valid_q;
  assign instr_o       = instr_q;
  assign pc_out_o      = pc_out_q;
  assign pc4_out_o     = pc4_q;

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Program-counter register and instruction-fetch sequencer for the CPU front end.
- Holds the fetch PC and issues one instruction-memory request at a time.
- Presents the returned instruction with its pc and pc+4 to decode.
- Applies branch, jump, jr and exception redirects with fixed priority, discarding any wrong-path fetch already in flight.

Parameters:
RESET_PC, 32'h0000_3000, first fetch address after reset
EXC_VECTOR, 32'h0000_4180, redirect target when exc is asserted

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  decode cannot accept; held instruction stays valid
branch_taken  input  1  branch redirect request
branch_target  input  32  branch target address
jump  input  1  j/jal redirect request
jump_target  input  32  jump target address
jr  input  1  jr/jalr redirect request
jr_target  input  32  register target address
exc  input  1  exception redirect to EXC_VECTOR
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address, word aligned
imem_gnt  input  1  memory accepted request this cycle
imem_rvalid  input  1  read data valid (one cycle per accepted request)
imem_rdata  input  32  instruction word
instr_valid  output  1  instr/pc_out/pc4_out valid for decode
instr  output  32  fetched instruction
pc_out  output  32  address of instr
pc4_out  output  32  pc_out + 4, for link/sequential use

Behaviour:
- All outputs are registered.
- Reset values:
  - state=IDLE, imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, drop=0.
  - instr_valid=0, instr=0, pc_out=RESET_PC, pc4_out=RESET_PC+4.
- Reset asserted in any state, including WAIT with a request outstanding, returns to these values next edge.
- A late imem_rvalid for a request accepted before reset is ignored, because rvalid is only sampled in WAIT.
- redirect = exc|jr|jump|branch_taken.
- Target priority: exc (EXC_VECTOR) > jr > jump > branch.
- Target bits [1:0] are forced to 00.
- imem_addr always equals fetch_pc.
- States:
  - IDLE: one cycle after reset deasserts. Go to REQ. A redirect in this cycle loads fetch_pc.
  - REQ: imem_req=1.
    - No gnt, redirect: fetch_pc<=target, stay in REQ. The address is only sampled on gnt.
    - gnt, no redirect: go to WAIT.
    - gnt and redirect in the same cycle: the old address is in flight. drop<=1, fetch_pc<=target, go to WAIT.
  - WAIT: imem_req=0.
    - Redirect: drop<=1, fetch_pc<=target. If several redirects arrive while waiting, the last one wins.
    - rvalid with drop (including a redirect in this same cycle): discard data, drop<=0, go to REQ.
    - rvalid without drop: instr<=imem_rdata, pc_out<=fetch_pc, pc4_out<=fetch_pc+4, fetch_pc<=fetch_pc+4, instr_valid<=1, go to OUT.
  - OUT: instr_valid=1, all outputs held stable.
    - Consumed means !stall.
    - Consumed or redirect: instr_valid<=0, go to REQ. If redirect, fetch_pc<=target.
    - Stall with redirect: the held instruction is flushed.
    - Stall without redirect: hold.
- stall has no effect in IDLE, REQ or WAIT.
- Arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000. Same for pc4_out.
- Minimum fetch period with gnt in the REQ cycle and rvalid the following cycle: REQ->WAIT->OUT->REQ, i.e. 3 cycles per instruction.
- At most one request is outstanding. imem_req is never asserted in WAIT or OUT.

Test Plan:
- Reset for 2 cycles, then release; memory grants immediately and returns rdata the next cycle. Required:
  - imem_req rises 2 cycles after release with imem_addr=0x3000.
  - instr_valid with pc_out=0x3000, pc4_out=0x3004.
  - Next fetches at 0x3004 and 0x3008, one every 3 cycles.
- Hold stall=1 for 4 cycles while in OUT. Required: instr, pc_out and instr_valid stay stable, and no imem_req. After stall drops, the next request goes to 0x3004.
- branch_taken=1, target 0x3101, during WAIT. Required: the returning word is discarded with instr_valid staying 0, and the next imem_addr is 0x3100.
- exc, jr and jump asserted together in REQ with no gnt. Required: imem_addr becomes 0x4180 the next cycle, and gnt is then accepted at 0x4180.
- jump to 0xFFFF_FFFC, then fetch. Required: pc_out=0xFFFF_FFFC, pc4_out=0x0, and the next imem_addr is 0x0.
- reset asserted in WAIT, then rvalid returns 1 cycle later. Required: data is ignored, instr_valid stays 0, and the fetch restarts at 0x3000.
